// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: funct3 access encodings, FSM
// state type, byte-enable base patterns and the access legality check.
package mem_stage_pkg;

    // funct3 access size / signedness encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable patterns for lane 0; shifted up by addr[1:0] for stores.
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [0:0] {
        IDLE,
        ACCESS
    } state_e;

    // True when a memory op with this size/direction/address may be issued.
    // Only meaningful when rd or wr is set.
    function automatic logic access_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        if (!(rd && wr)) begin
            case (f3)
                F3_B:    ok = 1'b1;
                F3_H:    ok = !addr_lo[0];
                F3_W:    ok = (addr_lo == 2'b00);
                F3_BU:   ok = rd;
                F3_HU:   ok = rd && !addr_lo[0];
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: selects the addressed byte/halfword lane of the
// returned memory word and sign- or zero-extends it according to funct3.
// Ports:
//   dmemRdata  in  raw 32-bit word from data memory
//   addr       in  byte offset within the word
//   funct3     in  access size / signedness
//   data       out formatted load value (0 for unknown funct3)
module load_formatter
    import mem_stage_pkg::*;
(
    input  logic [31:0] dmemRdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        shifted   = dmemRdata >> {addr, 3'b000};
        byte_lane = shifted[7:0];
        // Halfword accesses are 2-byte aligned, so addr[1] picks the half.
        half_lane = addr[1] ? dmemRdata[31:16] : dmemRdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
            F3_H:    data = {{16{half_lane[15]}}, half_lane};
            F3_W:    data = dmemRdata;
            F3_BU:   data = {24'h0, byte_lane};
            F3_HU:   data = {16'h0, half_lane};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage. Registers the execute-stage results, performs
// load/store accesses over a req/ack data-memory handshake, formats load
// data and presents the branch decision. Holds off upstream (busy) while
// an access is outstanding.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   inValid, aluRes, data2,      execute-stage results and control
//   mux1In, zero, memRead,
//   memWrite, branch, funct3
//   busy                         stage cannot accept a new op
//   dmemReq/We/Addr/Wdata/Be     data-memory request (held until ack)
//   dmemRdata, dmemAck           data-memory response
//   outValid                     one-cycle result strobe toward writeback
//   memData, aluResOut,          registered results; pcSrc and memErr
//   pcSrc, branchTarget, memErr  are qualified by outValid
// Only DATA_W = 32 is supported; ADDR_W must not exceed DATA_W.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inValid,
    input  logic [DATA_W-1:0] aluRes,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] mux1In,
    input  logic              zero,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              branch,
    input  logic [2:0]        funct3,
    output logic              busy,
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [ADDR_W-1:0] dmemAddr,
    output logic [DATA_W-1:0] dmemWdata,
    output logic [3:0]        dmemBe,
    input  logic [DATA_W-1:0] dmemRdata,
    input  logic              dmemAck,
    output logic              outValid,
    output logic [DATA_W-1:0] memData,
    output logic [DATA_W-1:0] aluResOut,
    output logic              pcSrc,
    output logic [DATA_W-1:0] branchTarget,
    output logic              memErr
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] alu_res_q;
    logic [DATA_W-1:0] target_q;
    logic              pc_src_q;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic              load_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        be_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_err_q;
    logic              out_valid_q;

    logic              capture;
    logic              mem_op;
    logic              legal;
    logic              start_access;
    logic              ack_taken;
    logic [DATA_W-1:0] wdata_fmt;
    logic [3:0]        be_fmt;
    logic [DATA_W-1:0] load_data;

    assign busy         = (state_q == ACCESS);
    assign capture      = inValid && !busy;
    assign mem_op       = memRead || memWrite;
    assign legal        = access_legal(memRead, memWrite, funct3, aluRes[1:0]);
    assign start_access = capture && mem_op && legal;
    assign ack_taken    = busy && dmemAck;

    // Store lane replication and byte enables, computed at capture time so
    // the request fields are plain registers while the access is pending.
    always_comb begin
        wdata_fmt = data2;
        be_fmt    = BE_WORD;
        if (memWrite) begin
            case (funct3)
                F3_B: begin
                    wdata_fmt = {4{data2[7:0]}};
                    be_fmt    = BE_BYTE << aluRes[1:0];
                end
                F3_H: begin
                    wdata_fmt = {2{data2[15:0]}};
                    be_fmt    = BE_HALF << aluRes[1:0];
                end
                default: begin
                    wdata_fmt = data2;
                    be_fmt    = BE_WORD;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_access) state_d = ACCESS;
            ACCESS:  if (dmemAck) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    load_formatter u_load_formatter (
        .dmemRdata (dmemRdata),
        .addr      (alu_res_q[1:0]),
        .funct3    (funct3_q),
        .data      (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_res_q   <= '0;
            target_q    <= '0;
            pc_src_q    <= 1'b0;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            load_q      <= 1'b0;
            wdata_q     <= '0;
            be_q        <= 4'b0000;
            mem_data_q  <= '0;
            mem_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            if (capture) begin
                alu_res_q   <= aluRes;
                target_q    <= mux1In;
                pc_src_q    <= branch && zero;
                funct3_q    <= funct3;
                we_q        <= memWrite && legal;
                load_q      <= memRead && legal;
                wdata_q     <= wdata_fmt;
                be_q        <= be_fmt;
                mem_data_q  <= '0;
                mem_err_q   <= mem_op && !legal;
                // Non-memory and rejected ops complete immediately.
                out_valid_q <= !start_access;
            end else if (ack_taken) begin
                out_valid_q <= 1'b1;
                if (load_q) begin
                    mem_data_q <= load_data;
                end
            end
        end
    end

    assign dmemReq      = busy;
    assign dmemWe       = busy && we_q;
    assign dmemAddr     = {alu_res_q[ADDR_W-1:2], 2'b00};
    assign dmemWdata    = wdata_q;
    assign dmemBe       = be_q;
    assign outValid     = out_valid_q;
    assign memData      = mem_data_q;
    assign aluResOut    = alu_res_q;
    assign pcSrc        = pc_src_q;
    assign branchTarget = target_q;
    assign memErr       = mem_err_q;

endmodule
